eth_frame_filter: RTL

//  Consumes the RMII receiver's post-SFD dibit stream (valid/2-bit data, wire order) and assembles bytes.

---
 rtl/eth_pkg.sv | 25 ++
 rtl/dibit_to_byte.sv | 34 +++
 rtl/eth_frame_filter.sv | 112 +++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet frame filter.
package eth_pkg;

   localparam int MAC_W = 48;
   localparam logic [MAC_W-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
   localparam int HDR_BYTES = 14;

   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DROP} filt_state_t;

   // Byte idx of a MAC address in wire order (byte 0 = bits [47:40]); 0 beyond the address.
   function automatic logic [7:0] mac_byte(input logic [MAC_W-1:0] mac, input logic [3:0] idx);
      logic [7:0] b;
      case (idx)
         4'd0:    b = mac[47:40];
         4'd1:    b = mac[39:32];
         4'd2:    b = mac[31:24];
         4'd3:    b = mac[23:16];
         4'd4:    b = mac[15:8];
         4'd5:    b = mac[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/dibit_to_byte.sv
// Assembles RMII dibits (LSB first) into bytes. The completed byte and its strobe are
// combinational on the cycle the 4th dibit is present, so the consumer can register them.
module dibit_to_byte (
   input  logic       clk,
   input  logic       rst,
   input  logic       axiiv,
   input  logic [1:0] axiid,
   output logic [7:0] data_byte,
   output logic       byte_valid
);

   logic [1:0] cnt;
   logic [5:0] part;

   // Dibit counter and partial-byte shifter; any gap in axiiv restarts at dibit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= 2'd0;
         part <= 6'd0;
      end else if (!axiiv) begin
         cnt  <= 2'd0;
      end else begin
         cnt  <= cnt + 2'd1;
         part <= {axiid, part[5:2]};
      end
   end

   // Fourth dibit lands in [7:6]; the earlier three are already in place.
   always_comb begin
      data_byte  = {axiid, part};
      byte_valid = axiiv && (cnt == 2'd3);
   end

endmodule

// File: rtl/eth_frame_filter.sv
// Destination-MAC frame filter: strips the Ethernet header, forwards payload (with FCS).
module eth_frame_filter
   import eth_pkg::*;
#(
   parameter logic [MAC_W-1:0] MY_MAC       = 48'h69_69_5A_06_54_91,
   parameter int               HEADER_BYTES = HDR_BYTES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        axiiv,
   input  logic [1:0]  axiid,
   output logic        axiov,
   output logic [7:0]  axiod,
   output logic [15:0] ethertype,
   output logic        frame_done,
   output logic        frame_drop
);

   localparam logic [3:0] LAST_IDX   = 4'(HEADER_BYTES - 1);
   localparam logic [3:0] ETH_HI_IDX = 4'(HEADER_BYTES - 2);
   localparam logic [3:0] DST_LAST   = 4'd5;

   filt_state_t state;
   logic [3:0]  hdr_idx;
   logic        ucast;
   logic        bcast;
   logic [7:0]  eth_hi;
   logic [7:0]  data_byte;
   logic        byte_valid;
   logic        ucast_nxt;
   logic        bcast_nxt;

   dibit_to_byte u_dibit_to_byte (
      .clk       (clk),
      .rst       (rst),
      .axiiv     (axiiv),
      .axiid     (axiid),
      .data_byte (data_byte),
      .byte_valid(byte_valid)
   );

   // Match flags as they would stand after folding in the current header byte.
   always_comb begin
      ucast_nxt = ucast && (data_byte == mac_byte(MY_MAC, hdr_idx));
      bcast_nxt = bcast && (data_byte == 8'hFF);
   end

   // Filter FSM with registered strobes; byte 12 is staged so a runt never touches ethertype.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hdr_idx    <= 4'd0;
         ucast      <= 1'b0;
         bcast      <= 1'b0;
         eth_hi     <= 8'd0;
         ethertype  <= 16'd0;
         axiov      <= 1'b0;
         axiod      <= 8'd0;
         frame_done <= 1'b0;
         frame_drop <= 1'b0;
      end else begin
         axiov      <= 1'b0;
         frame_done <= 1'b0;
         frame_drop <= 1'b0;
         unique case (state)
            IDLE: begin
               if (axiiv) begin
                  state   <= HEADER;
                  hdr_idx <= 4'd0;
                  ucast   <= 1'b1;
                  bcast   <= 1'b1;
               end
            end
            HEADER: begin
               if (!axiiv) begin
                  state      <= IDLE;
                  frame_drop <= 1'b1;
               end else if (byte_valid) begin
                  hdr_idx <= hdr_idx + 4'd1;
                  if (hdr_idx <= DST_LAST) begin
                     ucast <= ucast_nxt;
                     bcast <= bcast_nxt;
                  end
                  if (hdr_idx == DST_LAST && !ucast_nxt && !bcast_nxt) begin
                     state      <= DROP;
                     frame_drop <= 1'b1;
                  end
                  if (hdr_idx == ETH_HI_IDX) eth_hi <= data_byte;
                  if (hdr_idx == LAST_IDX) begin
                     ethertype <= {eth_hi, data_byte};
                     state     <= PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               if (!axiiv) begin
                  state      <= IDLE;
                  frame_done <= 1'b1;
               end else if (byte_valid) begin
                  axiov <= 1'b1;
                  axiod <= data_byte;
               end
            end
            DROP: begin
               if (!axiiv) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
